// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the dual-clock FIFO write-side arbiter.
// The header helper is only referenced when FIFO_WR_ARB_TAG_EN is defined.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Header word: requester id in the LSBs, upper bits zero; 4 bits covers 16 requesters.
  localparam int HDR_ID_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [15:0] hdr_word(input logic [HDR_ID_W-1:0] id);
    return {{(16-HDR_ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        idx = cand_idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter for the dual-clock FIFO, one burst per grant.
// Build option FIFO_WR_ARB_TAG_EN inserts a one-word requester-id header per burst.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no grant; pick next requester from rr_ptr, no FIFO write
//   ST_HDR  | (tag builds only) write the id header word when not full
//   ST_XFER | forward granted requester's words until last or MAXBURST
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 8
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wfull,
  output logic                   winc,
  output logic [DSIZE-1:0]       wdata,
  output logic                   grant_vld,
  output logic [clog2(NREQ)-1:0] grant_id
);

  localparam int IW = clog2(NREQ);
  localparam int BW = clog2(MAXBURST + 1);

  arb_state_e       state, state_nxt;
  logic [IW-1:0]    rr_ptr, ptr_nxt;
  logic [IW-1:0]    grant_nxt, pick_idx, ptr_inc;
  logic [BW-1:0]    beat_cnt, beat_nxt;
  logic             pick_any;
  logic             sel_valid, sel_last, accept, burst_end;
  logic [DSIZE-1:0] sel_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign ptr_inc   = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign burst_end = sel_last || (beat_cnt == BW'(MAXBURST - 1));
  assign accept    = (state == ST_XFER) && sel_valid && !wfull;
  assign grant_vld = (state != ST_IDLE);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    grant_nxt = grant_id;
    beat_nxt  = beat_cnt;
    winc      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          beat_nxt  = '0;
`ifdef FIFO_WR_ARB_TAG_EN
          state_nxt = ST_HDR;
`else
          state_nxt = ST_XFER;
`endif
        end
      end
`ifdef FIFO_WR_ARB_TAG_EN
      ST_HDR: begin
        if (!wfull) begin
          winc      = 1'b1;
          wdata     = DSIZE'(hdr_word(HDR_ID_W'(grant_id)));
          state_nxt = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = (grant_id == IW'(i)) && !wfull;
        end
        wdata = sel_data;
        winc  = accept;
        // last and the burst limit on the same beat collapse into one release
        if (accept) begin
          beat_nxt = beat_cnt + 1'b1;
          if (burst_end) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = ptr_inc;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: per-cycle reference model feeds expectation queues,
// a separate monitor pops and compares; directed scenarios then randomized traffic.
module tb_fifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  grant_vld;
  logic [1:0]            grant_id;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Source model: each requester holds a queue of {last, data} words.
  logic [8:0]      src_q [NREQ][$];
  logic [NREQ-1:0] acc = '0;
  int              bub_pct = 0;
  int              full_pct = 0;
  int              full_hold = 0;
  bit              chk_en = 1'b0;

  always @(negedge wclk) begin
    #2;
    acc = req_valid & req_ready;
  end

  always @(posedge wclk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req_valid[i]           = ($urandom_range(99) >= bub_pct);
        req_data[i*DSIZE +: DSIZE] = src_q[i][0][7:0];
        req_last[i]            = src_q[i][0][8];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
        req_last[i]            = 1'b0;
      end
    end
    acc = '0;
    if (full_hold > 0) begin
      wfull = 1'b1;
      full_hold--;
    end else begin
      wfull = ($urandom_range(99) < full_pct);
    end
  end

  // Reference model of the arbiter, one evaluation per cycle.
  typedef struct packed {
    logic       gv;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       wi;
    logic [7:0] wd;
  } st_t;

  st_t        exp_st[$];
  logic [7:0] exp_wr[$];
  int         wr_seen = 0;
  bit         m_busy = 1'b0;
  bit         m_hdr = 1'b0;
  int         m_gid = 0;
  int         m_cnt = 0;
  int         m_ptr = 0;

  task automatic model_reset();
    m_busy = 1'b0;
    m_hdr  = 1'b0;
    m_gid  = 0;
    m_cnt  = 0;
    m_ptr  = 0;
  endtask

  always @(negedge wclk) begin
    st_t        e;
    logic [1:0] c;
    logic [1:0] g;
    if (chk_en) begin
      e     = '0;
      e.gv  = m_busy;
      e.gid = 2'(m_gid);
      g     = 2'(m_gid);
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          c = 2'((m_ptr + k) % NREQ);
          if (!m_busy && req_valid[c]) begin
            m_busy = 1'b1;
            m_hdr  = TAG;
            m_gid  = int'(c);
            m_cnt  = 0;
          end
        end
      end else if (m_hdr) begin
        if (!wfull) begin
          e.wi = 1'b1;
          e.wd = 8'(m_gid);
          exp_wr.push_back(8'(m_gid));
          m_hdr = 1'b0;
        end
      end else begin
        e.rdy[g] = !wfull;
        e.wd     = 8'(req_data >> (DSIZE * m_gid));
        if (req_valid[g] && !wfull) begin
          e.wi = 1'b1;
          exp_wr.push_back(e.wd);
          m_cnt++;
          if (req_last[g] || m_cnt == MAXBURST) begin
            m_busy = 1'b0;
            m_ptr  = (m_gid + 1) % NREQ;
          end
        end
      end
      exp_st.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge wclk) begin
    st_t e;
    #1;
    if (chk_en) begin
      if (exp_st.size() == 0) begin
        flag("cycle_expectation_missing");
      end else begin
        e = exp_st.pop_front();
        chk("grant_vld", grant_vld, e.gv);
        chk("grant_id", grant_id, e.gid);
        chk("req_ready", req_ready, e.rdy);
        chk("winc", winc, e.wi);
        chk("wdata", wdata, e.wd);
      end
      if (winc) begin
        wr_seen++;
        if (exp_wr.size() == 0) flag("unexpected_write");
        else chk("write_word", wdata, exp_wr.pop_front());
      end
    end
  end

  function automatic bit srcs_busy();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && (srcs_busy() || m_busy)) begin
      @(negedge wclk);
      n++;
    end
    if (n >= budget) flag({"drain_timeout_", nm});
    repeat (2) @(negedge wclk);
    #3;
  endtask

  task automatic push_pkt(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) src_q[r].push_back({(k == len - 1), 8'(base + k)});
  endtask

  int base_wr;
  int n;

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b1;
    #2 wrst_n = 1'b0;
    repeat (3) @(posedge wclk);
    #3;
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_winc", winc, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wdata", wdata, 0);
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // single requester, three words
    base_wr = wr_seen;
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h12});
    src_q[1].push_back({1'b1, 8'h13});
    drain("s1", 100);
    chk("s1_word_count", wr_seen - base_wr, TAG ? 4 : 3);

    // everyone busy with one-word packets
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push_pkt(i, 1, 8'(8'h20 + 4 * r + i));
    drain("s2", 200);

    // long stream without last, competitors in between
    for (int k = 0; k < 10; k++) src_q[2].push_back({1'b0, 8'(8'h30 + k)});
    push_pkt(0, 2, 8'h50);
    push_pkt(3, 2, 8'h60);
    n = 0;
    while (n < 300 && srcs_busy()) begin
      @(negedge wclk);
      n++;
    end
    if (n >= 300) flag("s3_stream_timeout");
    repeat (3) @(negedge wclk);
    #3;
    chk("s3_grant_held", grant_vld, 1);
    chk("s3_grant_id", grant_id, 2);
    src_q[2].push_back({1'b1, 8'h3A});
    drain("s3", 100);

    // full stall in the middle of a four-word burst
    base_wr = wr_seen;
    push_pkt(0, 4, 8'h70);
    n = 0;
    while (n < 50 && wr_seen < base_wr + (TAG ? 3 : 2)) begin
      @(negedge wclk);
      #2;
      n++;
    end
    if (n >= 50) flag("s4_wait_timeout");
    full_hold = 3;
    drain("s4", 100);
    chk("s4_word_count", wr_seen - base_wr, TAG ? 5 : 4);

    // randomized traffic with bubbles and backpressure
    bub_pct  = 20;
    full_pct = 25;
    for (int p = 0; p < 250; p++) begin
      repeat ($urandom_range(6)) @(posedge wclk);
      push_pkt($urandom_range(NREQ - 1), $urandom_range(1, 6), 8'($urandom_range(255)));
    end
    drain("random", 8000);
    bub_pct  = 0;
    full_pct = 0;

    // asynchronous reset in the middle of a burst
    push_pkt(3, 6, 8'h90);
    n = 0;
    while (n < 50 && !winc) begin
      @(negedge wclk);
      #1;
      n++;
    end
    if (n >= 50) flag("s5_wait_timeout");
    @(posedge wclk);
    #2;
    chk_en = 1'b0;
    wrst_n = 1'b0;
    #1;
    chk("s5_rst_winc", winc, 0);
    chk("s5_rst_req_ready", req_ready, 0);
    chk("s5_rst_grant_vld", grant_vld, 0);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_st.delete();
    exp_wr.delete();
    push_pkt(3, 2, 8'hB0);
    push_pkt(1, 2, 8'hC0);
    repeat (2) @(posedge wclk);
    #2;
    wrst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    n = 0;
    while (n < 10 && !grant_vld) begin
      @(negedge wclk);
      #3;
      n++;
    end
    if (n >= 10) flag("s5_regrant_timeout");
    chk("s5_first_grant", grant_id, 1);
    drain("s5", 100);

    chk("leftover_writes", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side arbiter for the dual-clock FIFO. It shares the FIFO write port among NREQ requesters in the write clock domain and drives `winc`/`wdata` directly from the FIFO's `wfull` flag. Arbitration is round-robin, one burst per grant. A burst ends on the requester's `last` beat or after MAXBURST accepted words. Never writes when `wfull` is high.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DSIZE, 8: data width; must match the FIFO's DSIZE.
- MAXBURST, 8: max words per grant, ≥1.
- wclk  in  1  write clock; all logic on rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  final word of requester's packet.
- req_ready  out  NREQ  one-hot or zero; word accepted when valid&ready.
- wfull  in  1  FIFO full flag (wclk domain).
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- grant_vld  out  1  a grant is held (state not IDLE).
- grant_id  out  clog2(NREQ)  current/last granted requester.

## Operation
- States: IDLE, HDR (only with tag feature), XFER.
- IDLE:
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Register the pick into `grant_id` and clear `beat_cnt`.
  - Next state is HDR if the tag feature is compiled in, else XFER.
  - No write occurs in IDLE.
- XFER:
  - `winc = req_valid[grant_id] & ~wfull`.
  - `req_ready[grant_id] = ~wfull`. All other `req_ready` bits are 0.
  - `wdata = req_data[grant_id]`.
  - Each accepted beat (`winc` = 1) increments `beat_cnt`.
- Release: on an accepted beat with `req_last[grant_id]`, or with `beat_cnt == MAXBURST-1`:
  - Go to IDLE.
  - `rr_ptr <= (grant_id+1) mod NREQ`.
- Bubbles: `req_valid` low mid-burst means the grant is held indefinitely. There is no timeout.
- `wfull` high: `winc`, `req_ready` and `beat_cnt` are frozen at 0/hold. The requester must hold its data. No word is lost or duplicated.
- `wdata` is 0 whenever `winc` = 0 and the state is not XFER.
- `beat_cnt` width is clog2(MAXBURST+1). It never exceeds MAXBURST-1 in XFER.
- Simultaneous `last` and MAXBURST limit: a single release.
- `req_last` is ignored on non-accepted cycles.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0, `grant_vld` 0, `winc` 0, `req_ready` 0, `wdata` 0.
- Reset mid-burst aborts immediately (asynchronous). The partial packet already written stays in the FIFO.
- Arbitration latency: 1 cycle. A requester valid in IDLE cycle T sees its first `req_ready` in T+1 (T+2 with tag).
- Throughput: 1 word/cycle within a burst. There is exactly 1 idle cycle between bursts.
- `winc`, `req_ready` and `wdata` are combinational from the registered state/`grant_id` plus `wfull`/`req_valid`/`req_data`.
- `wfull` is the FIFO's registered flag. Combinational gating makes the same-cycle full update safe.

## Configuration
- Macro name: `FIFO_WR_ARB_TAG_EN`.
- When defined:
  - HDR state is inserted after IDLE.
  - HDR writes one header word `{ {DSIZE-clog2(NREQ){1'b0}}, grant_id }` when `~wfull`. `winc` is high that cycle and all `req_ready` bits are 0.
  - It then moves to XFER.
  - The header does not count toward MAXBURST.
  - Requires DSIZE ≥ clog2(NREQ).
- Undefined: no HDR state; IDLE goes straight to XFER; the FIFO carries only payload.

## Structure
- Package `fifo_wr_arb_pkg`:
  - state encoding constants (IDLE=0, HDR=1, XFER=2, 2-bit);
  - header-format constant;
  - clog2 function.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: NREQ request vector, start pointer. Outputs: winner index and any-request flag.
- Expected size: 150–250 lines total.

## Test plan
All scenarios use NREQ=4, DSIZE=8, MAXBURST=4 unless noted.

1. Req 1 only, words 0x11, 0x12, 0x13 with last on 0x13.
   - Required: IDLE 1 cycle, then `winc` for 3 consecutive cycles with `wdata` 0x11, 0x12, 0x13.
   - Then `grant_vld`=0 and `rr_ptr`=2.
2. All 4 requesters continuously valid with 1-word packets.
   - Required: `grant_id` sequence 0, 1, 2, 3, 0, 1, with one IDLE cycle between grants.
3. Req 2 streams 10 words, never asserting last.
   - Required: bursts of 4 words, 4 words, then 2 words. Other valid requesters are served between bursts.
4. `wfull` high for 3 cycles after word 2 of a 4-word burst.
   - Required: `winc`=0 and `req_ready`=0 for those 3 cycles.
   - Word 3 is written on the cycle `wfull` drops; the total written is exactly 4.
5. `wrst_n` asserted mid-XFER.
   - Required: the same cycle gives `winc`=0, `req_ready`=0, `grant_vld`=0.
   - After release, the first grant goes to the lowest valid index from 0.
6. With `FIFO_WR_ARB_TAG_EN`, req 2 sends 0xA0, 0xA1 (last).
   - Required: FIFO write sequence 0x02, 0xA0, 0xA1.
   - `req_ready[2]` is 0 on the header cycle.
